m_stage_dm: RTL

Memory-stage data memory of the five-stage pipelined MIPS core. It sits directly downstream of the E/M pipeline register and is the consumer of that register's memory-side fields: address, store data, write strobe, byte flag and PC. It performs word and byte loads and stores, commits stores on the clock edge, and emits the load word toward the M/W register. It also emits the store trace line consumed by the course checker and keeps sticky fault flags plus a store counter for debug.

---
 rtl/dm_pkg.sv | 27 ++
 rtl/dm_byte_lane.sv | 33 +++
 rtl/m_stage_dm.sv | 102 ++++++++++
 3 files changed

// File: rtl/dm_pkg.sv
// Shared constants and types for the M-stage data memory.
package dm_pkg;

    // Default depth: 3072 words = 12 KiB, byte addresses 0x0000-0x2FFF.
    localparam int          DM_WORDS_DEF = 3072;
    localparam logic [31:0] DM_BASE      = 32'h0;

    // Byte-lane geometry of a 32-bit word.
    localparam int LANE_W    = 2;
    localparam int NUM_LANES = 4;
    localparam int BYTE_W    = 8;

    // Format of the store trace line read by the course checker:
    // PC, word-aligned byte address, merged word as written.
    localparam string TRACE_FMT = "@%h: *%h <= %h";

    typedef enum logic {
        ACC_WORD = 1'b0,
        ACC_BYTE = 1'b1
    } acc_size_e;

    // Sign-extend one byte to a full word (lb).
    function automatic logic [31:0] sext8(input logic [BYTE_W-1:0] b);
        return {{(32-BYTE_W){b[BYTE_W-1]}}, b};
    endfunction

endpackage

// File: rtl/dm_byte_lane.sv
// Combinational byte-lane steering: store merge and load extract.
module dm_byte_lane
    import dm_pkg::*;
(
    input  logic [31:0]       old_word,
    input  logic [31:0]       wdata,
    input  logic [LANE_W-1:0] lane,
    input  acc_size_e         size,
    output logic [31:0]       new_word,
    output logic [31:0]       rdata
);

    logic [BYTE_W-1:0] sel_byte;

    // Per-lane merge: a word store replaces every lane, a byte store only
    // the addressed lane (with wdata[7:0]); the rest keep the old byte.
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        always_comb begin
            new_word[g*BYTE_W +: BYTE_W] = old_word[g*BYTE_W +: BYTE_W];
            if (size == ACC_WORD)
                new_word[g*BYTE_W +: BYTE_W] = wdata[g*BYTE_W +: BYTE_W];
            else if (lane == LANE_W'(g))
                new_word[g*BYTE_W +: BYTE_W] = wdata[BYTE_W-1:0];
        end
    end

    // Load extract: full word, or the addressed lane sign-extended.
    always_comb begin
        sel_byte = old_word[lane*BYTE_W +: BYTE_W];
        rdata    = (size == ACC_BYTE) ? sext8(sel_byte) : old_word;
    end

endmodule

// File: rtl/m_stage_dm.sv
// M-stage data memory: combinational loads, edge-committed word/byte
// stores, sticky fault flags, store counter and a store trace port.
module m_stage_dm
    import dm_pkg::*;
#(
    parameter int DM_WORDS = DM_WORDS_DEF,
    parameter bit LOG_EN   = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        MemWrite_M,
    input  logic        Byte_M,
    input  logic [31:0] PC_M,
    input  logic [31:0] aluR_M,
    input  logic [31:0] RD2_M,
    output logic [31:0] RD_M,
    output logic        align_err,
    output logic        range_err,
    output logic [31:0] st_cnt,
    // Store trace: one pulse per commit; fields print with TRACE_FMT.
    output logic        trace_vld,
    output logic [31:0] trace_pc,
    output logic [31:0] trace_addr,
    output logic [31:0] trace_word
);

    localparam int IDX_W = $clog2(DM_WORDS);

    logic [31:0]       mem [DM_WORDS];

    logic [31:0]       off;
    logic [IDX_W-1:0]  idx;
    logic [LANE_W-1:0] lane;
    logic              in_range;
    logic              commit;
    logic [31:0]       cur_word;
    logic [31:0]       merged;
    logic [31:0]       ld_data;
    acc_size_e         size;

    // Address decode: word index and byte lane relative to the memory base.
    always_comb begin
        off      = aluR_M - DM_BASE;
        idx      = off[IDX_W+1:2];
        lane     = off[LANE_W-1:0];
        in_range = off < 32'(DM_WORDS * 4);
        size     = acc_size_e'(Byte_M);
        cur_word = in_range ? mem[idx] : 32'h0;
        commit   = en & MemWrite_M & in_range & ~reset;
    end

    dm_byte_lane u_lane (
        .old_word (cur_word),
        .wdata    (RD2_M),
        .lane     (lane),
        .size     (size),
        .new_word (merged),
        .rdata    (ld_data)
    );

    // Load path has no bypass: a same-cycle store is visible next cycle.
    always_comb begin
        RD_M = in_range ? ld_data : 32'h0;
    end

    // Memory array: full clear on reset, otherwise commit the merged word.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DM_WORDS; i++) mem[i] <= 32'h0;
        end else if (commit) begin
            mem[idx] <= merged;
        end
    end

    // Sticky fault flags. No load-qualify input reaches this block, so only
    // enabled stores count as valid accesses for fault reporting.
    always_ff @(posedge clk) begin
        if (reset) begin
            align_err <= 1'b0;
            range_err <= 1'b0;
        end else if (en && MemWrite_M) begin
            if (size == ACC_WORD && lane != '0) align_err <= 1'b1;
            if (!in_range)                      range_err <= 1'b1;
        end
    end

    // Committed-store counter, free-running wrap at 2^32.
    always_ff @(posedge clk) begin
        if (reset)       st_cnt <= 32'h0;
        else if (commit) st_cnt <= st_cnt + 32'h1;
    end

    // Trace fields describe the store about to land at the coming edge.
    always_comb begin
        trace_vld  = LOG_EN & commit;
        trace_pc   = PC_M;
        trace_addr = {aluR_M[31:2], 2'b00};
        trace_word = merged;
    end

endmodule
